// File: rtl/match_controller.sv
// Quidditch match sequencer: goal detection, kickoff hold/release, scores,
// match clock and game-over for the ball datapath and score overlay.
module match_controller #(
    parameter int unsigned GOAL_RADIUS     = 20,
    parameter int unsigned BALL_RADIUS     = 8,
    parameter int unsigned TICK_DIV        = 25000000,
    parameter int unsigned SERVE_TICKS     = 3,
    parameter int unsigned GOAL_HOLD_TICKS = 2,
    parameter int unsigned WIN_SCORE       = 5,
    parameter int unsigned MATCH_TICKS     = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       ball_hold,
    output logic       game_on,
    output logic       serve_to_team,
    output logic [3:0] score_team1,
    output logic [3:0] score_team2,
    output logic [7:0] time_left,
    output logic [1:0] goal_flash,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_GOAL  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SUB_W  = 8;
    localparam int unsigned D_W    = 11;
    localparam int unsigned SQ_W   = 22;
    localparam int unsigned SUM_W  = 23;
    localparam int unsigned HIT_R  = GOAL_RADIUS - BALL_RADIUS;
    localparam logic [SUM_W-1:0] HIT_R2 = SUM_W'(HIT_R * HIT_R);

    localparam logic [9:0] HOOP_X0 = 10'd300;
    localparam logic [9:0] HOOP_X1 = 10'd400;
    localparam logic [9:0] HOOP_X2 = 10'd500;
    localparam logic [9:0] RED_Y   = 10'd100;
    localparam logic [9:0] BLUE_Y  = 10'd450;

    // Strict inside-circle test of the ball centre against one hoop.
    function automatic logic hoop_hit(input logic [9:0] bx, input logic [9:0] by,
                                      input logic [9:0] hx, input logic [9:0] hy);
        logic signed [D_W-1:0] dx;
        logic signed [D_W-1:0] dy;
        logic [D_W-1:0]        ax;
        logic [D_W-1:0]        ay;
        logic [SQ_W-1:0]       sx;
        logic [SQ_W-1:0]       sy;
        logic [SUM_W-1:0]      sum;
        dx  = $signed({1'b0, bx}) - $signed({1'b0, hx});
        dy  = $signed({1'b0, by}) - $signed({1'b0, hy});
        ax  = dx[D_W-1] ? D_W'(-dx) : D_W'(dx);
        ay  = dy[D_W-1] ? D_W'(-dy) : D_W'(dy);
        sx  = SQ_W'(ax) * SQ_W'(ax);
        sy  = SQ_W'(ay) * SQ_W'(ay);
        sum = SUM_W'(sx) + SUM_W'(sy);
        return sum < HIT_R2;
    endfunction

    state_t             state, state_n;
    logic [TICK_W-1:0]  tick_cnt;
    logic [SUB_W-1:0]   sub_cnt;
    logic               start_q;
    logic               start_armed;
    logic               goal1_q, goal2_q;

    logic               tick_c, start_rise_c, red_hit_c, blue_hit_c, win_c;
    logic [7:0]         time_dec_c;
    logic               hold_n, on_n, over_n, serve_n;
    logic [3:0]         s1_n, s2_n;
    logic [7:0]         time_n;
    logic [1:0]         flash_n;

    assign red_hit_c  = hoop_hit(ball_x, ball_y, HOOP_X0, RED_Y)
                      | hoop_hit(ball_x, ball_y, HOOP_X1, RED_Y)
                      | hoop_hit(ball_x, ball_y, HOOP_X2, RED_Y);
    assign blue_hit_c = hoop_hit(ball_x, ball_y, HOOP_X0, BLUE_Y)
                      | hoop_hit(ball_x, ball_y, HOOP_X1, BLUE_Y)
                      | hoop_hit(ball_x, ball_y, HOOP_X2, BLUE_Y);

    // A button held through reset must be released before it can start a match.
    assign start_rise_c = start_btn & ~start_q & start_armed;
    assign tick_c       = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign time_dec_c   = (time_left != 8'd0) ? time_left - 8'd1 : 8'd0;
    assign win_c        = (score_team1 >= 4'(WIN_SCORE)) || (score_team2 >= 4'(WIN_SCORE));
    assign state_dbg    = state;

    always_comb begin
        state_n = state;
        serve_n = serve_to_team;
        s1_n    = score_team1;
        s2_n    = score_team2;
        time_n  = time_left;
        flash_n = goal_flash;
        case (state)
            S_IDLE, S_OVER: begin
                if (start_rise_c) begin
                    state_n = S_SERVE;
                    serve_n = 1'b0;
                    s1_n    = 4'd0;
                    s2_n    = 4'd0;
                    time_n  = 8'(MATCH_TICKS);
                    flash_n = 2'b00;
                end
            end
            S_SERVE: begin
                if (tick_c && (sub_cnt == SUB_W'(SERVE_TICKS - 1)))
                    state_n = S_PLAY;
            end
            S_PLAY: begin
                if (tick_c)
                    time_n = time_dec_c;
                // Team1 wins a simultaneous double hit; the conceding side gets the kickoff.
                if (goal1_q) begin
                    state_n = S_GOAL;
                    s1_n    = (score_team1 == 4'd15) ? score_team1 : score_team1 + 4'd1;
                    flash_n = 2'b01;
                    serve_n = 1'b1;
                end else if (goal2_q) begin
                    state_n = S_GOAL;
                    s2_n    = (score_team2 == 4'd15) ? score_team2 : score_team2 + 4'd1;
                    flash_n = 2'b10;
                    serve_n = 1'b0;
                end else if (time_n == 8'd0) begin
                    state_n = S_OVER;
                end
            end
            S_GOAL: begin
                if (tick_c && (sub_cnt == SUB_W'(GOAL_HOLD_TICKS - 1))) begin
                    flash_n = 2'b00;
                    state_n = (win_c || (time_left == 8'd0)) ? S_OVER : S_SERVE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        hold_n = (state_n != S_PLAY);
        on_n   = (state_n == S_PLAY);
        over_n = (state_n == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            tick_cnt      <= '0;
            sub_cnt       <= '0;
            start_q       <= 1'b0;
            start_armed   <= 1'b0;
            goal1_q       <= 1'b0;
            goal2_q       <= 1'b0;
            ball_hold     <= 1'b1;
            game_on       <= 1'b0;
            serve_to_team <= 1'b0;
            score_team1   <= 4'd0;
            score_team2   <= 4'd0;
            time_left     <= 8'(MATCH_TICKS);
            goal_flash    <= 2'b00;
            game_over     <= 1'b0;
        end else begin
            state       <= state_n;
            start_q     <= start_btn;
            start_armed <= start_armed | ~start_btn;
            goal1_q     <= (state == S_PLAY) & red_hit_c;
            goal2_q     <= (state == S_PLAY) & blue_hit_c;
            // Tick timing restarts on every state change.
            if (state_n != state) begin
                tick_cnt <= '0;
                sub_cnt  <= '0;
            end else if (tick_c) begin
                tick_cnt <= '0;
                sub_cnt  <= sub_cnt + SUB_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            ball_hold     <= hold_n;
            game_on       <= on_n;
            game_over     <= over_n;
            serve_to_team <= serve_n;
            score_team1   <= s1_n;
            score_team2   <= s2_n;
            time_left     <= time_n;
            goal_flash    <= flash_n;
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with short ticks (TICK_DIV=4).
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic [9:0] ball_x, ball_y;
    logic       ball_hold, game_on, serve_to_team, game_over;
    logic [3:0] score_team1, score_team2;
    logic [7:0] time_left;
    logic [1:0] goal_flash;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    match_controller #(
        .GOAL_RADIUS(20), .BALL_RADIUS(8), .TICK_DIV(4), .SERVE_TICKS(2),
        .GOAL_HOLD_TICKS(1), .WIN_SCORE(2), .MATCH_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .ball_x(ball_x), .ball_y(ball_y),
        .ball_hold(ball_hold), .game_on(game_on), .serve_to_team(serve_to_team),
        .score_team1(score_team1), .score_team2(score_team2), .time_left(time_left),
        .goal_flash(goal_flash), .game_over(game_over), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] bx;
        logic [9:0] by;
        int         st;
        int         s1;
        int         s2;
        int         flash;
        int         serve;
    } gvec_t;

    gvec_t vecs[8];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start_btn = 1'b0;
        ball_x    = 10'd100;
        ball_y    = 10'd275;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    // From IDLE/OVER: press start, then sit out the 8-cycle serve.
    task automatic enter_play();
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        chk("serve_entry", int'(state_dbg), 1);
        step(8);
        chk("play_entry", int'(state_dbg), 2);
    endtask

    initial begin
        vecs[0] = '{10'd400, 10'd450, 3, 0, 1, 2, 0};
        vecs[1] = '{10'd311, 10'd100, 3, 1, 0, 1, 1};
        vecs[2] = '{10'd312, 10'd100, 2, 0, 0, 0, 0};
        vecs[3] = '{10'd300, 10'd112, 2, 0, 0, 0, 0};
        vecs[4] = '{10'd500, 10'd439, 3, 0, 1, 2, 0};
        vecs[5] = '{10'd289, 10'd100, 3, 1, 0, 1, 1};
        vecs[6] = '{10'd488, 10'd450, 2, 0, 0, 0, 0};
        vecs[7] = '{10'd100, 10'd275, 2, 0, 0, 0, 0};

        // Reset state and kickoff timing
        do_reset();
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_hold", int'(ball_hold), 1);
        chk("rst_on", int'(game_on), 0);
        chk("rst_s1", int'(score_team1), 0);
        chk("rst_s2", int'(score_team2), 0);
        chk("rst_time", int'(time_left), 5);
        chk("rst_over", int'(game_over), 0);
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        chk("t1_serve", int'(state_dbg), 1);
        chk("t1_serve_hold", int'(ball_hold), 1);
        step(7);
        chk("t1_serve_late", int'(state_dbg), 1);
        step(1);
        chk("t1_play", int'(state_dbg), 2);
        chk("t1_play_hold", int'(ball_hold), 0);
        chk("t1_play_on", int'(game_on), 1);

        // Goal-detect vectors, each from a fresh kickoff
        for (int i = 0; i < 8; i++) begin
            do_reset();
            enter_play();
            ball_x = vecs[i].bx;
            ball_y = vecs[i].by;
            step(2);
            chk($sformatf("vec%0d_state", i), int'(state_dbg), vecs[i].st);
            chk($sformatf("vec%0d_s1", i), int'(score_team1), vecs[i].s1);
            chk($sformatf("vec%0d_s2", i), int'(score_team2), vecs[i].s2);
            chk($sformatf("vec%0d_flash", i), int'(goal_flash), vecs[i].flash);
            chk($sformatf("vec%0d_serve", i), int'(serve_to_team), vecs[i].serve);
        end

        // Two team2 goals end the match, then a restart
        do_reset();
        enter_play();
        ball_x = 10'd400;
        ball_y = 10'd450;
        step(2);
        chk("t2_goal1", int'(state_dbg), 3);
        chk("t2_goal1_on", int'(game_on), 0);
        chk("t2_goal1_hold", int'(ball_hold), 1);
        step(3);
        chk("t2_goal_hold", int'(state_dbg), 3);
        step(1);
        chk("t2_reserve", int'(state_dbg), 1);
        chk("t2_flash_clr", int'(goal_flash), 0);
        chk("t2_time_frozen", int'(time_left), 5);
        step(8);
        chk("t2_replay", int'(state_dbg), 2);
        step(2);
        chk("t2_goal2", int'(state_dbg), 3);
        chk("t2_goal2_s2", int'(score_team2), 2);
        step(4);
        chk("t2_over", int'(state_dbg), 4);
        chk("t2_over_flag", int'(game_over), 1);
        chk("t2_over_s2", int'(score_team2), 2);

        // Restart from OVER, then let the clock run out
        ball_x = 10'd100;
        ball_y = 10'd275;
        start_btn = 1'b1;
        step(1);
        start_btn = 1'b0;
        chk("t4_serve", int'(state_dbg), 1);
        chk("t4_s2_clr", int'(score_team2), 0);
        chk("t4_time", int'(time_left), 5);
        chk("t4_over_clr", int'(game_over), 0);
        step(8);
        chk("t4_play", int'(state_dbg), 2);
        for (int k = 1; k <= 5; k++) begin
            step(3);
            chk($sformatf("t4_pre_tick%0d", k), int'(time_left), 6 - k);
            step(1);
            chk($sformatf("t4_tick%0d", k), int'(time_left), 5 - k);
            chk($sformatf("t4_state%0d", k), int'(state_dbg), (k < 5) ? 2 : 4);
        end
        chk("t4_s1", int'(score_team1), 0);
        chk("t4_s2", int'(score_team2), 0);
        chk("t4_over_flag", int'(game_over), 1);

        // Goal on the same edge the clock hits zero
        do_reset();
        enter_play();
        step(18);
        chk("t5_time1", int'(time_left), 1);
        ball_x = 10'd400;
        ball_y = 10'd100;
        step(1);
        chk("t5_still_play", int'(state_dbg), 2);
        step(1);
        chk("t5_goal", int'(state_dbg), 3);
        chk("t5_s1", int'(score_team1), 1);
        chk("t5_time0", int'(time_left), 0);
        chk("t5_serve", int'(serve_to_team), 1);
        step(4);
        chk("t5_over", int'(state_dbg), 4);

        // Reset mid-GOAL with start held through release
        do_reset();
        enter_play();
        ball_x = 10'd300;
        ball_y = 10'd100;
        step(2);
        chk("t6_goal", int'(state_dbg), 3);
        chk("t6_s1", int'(score_team1), 1);
        step(1);
        rst       = 1'b1;
        start_btn = 1'b1;
        step(1);
        chk("t6_rst_state", int'(state_dbg), 0);
        chk("t6_rst_s1", int'(score_team1), 0);
        chk("t6_rst_flash", int'(goal_flash), 0);
        chk("t6_rst_hold", int'(ball_hold), 1);
        chk("t6_rst_time", int'(time_left), 5);
        chk("t6_rst_serve", int'(serve_to_team), 0);
        rst = 1'b0;
        step(3);
        chk("t6_held_idle", int'(state_dbg), 0);
        start_btn = 1'b0;
        step(1);
        chk("t6_released_idle", int'(state_dbg), 0);
        start_btn = 1'b1;
        step(1);
        chk("t6_serve", int'(state_dbg), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
